// File: rtl/coherence_control.sv
// Coherence controller for two snooping L1 dcaches sharing one RAM port.
// It arbitrates writebacks and coherent fills, and it sequences snoop, dirty writeback and line fill.
module coherence_control #(
   parameter int SNOOP_WAIT = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [1:0]        dREN,
   input  logic [1:0]        dWEN,
   input  logic [1:0][31:0]  daddr,
   input  logic [1:0][31:0]  dstore,
   input  logic [1:0]        cctrans,
   input  logic [1:0]        ccwrite,
   output logic [1:0]        dwait,
   output logic [1:0][31:0]  dload,
   output logic [1:0]        ccwait,
   output logic [1:0]        ccinv,
   output logic [1:0][31:0]  ccsnoopaddr,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [31:0]       ramaddr,
   output logic [31:0]       ramstore,
   input  logic [31:0]       ramload,
   input  logic [1:0]        ramstate
);

   localparam int CW = (SNOOP_WAIT > 1) ? $clog2(SNOOP_WAIT) : 1;
   localparam logic [CW-1:0] SNOOP_LAST = CW'(SNOOP_WAIT - 1);

   typedef enum logic [2:0] {IDLE, WB, SNOOP, SWB1, SWB2, LD1, LD2} state_t;

   state_t          state_q, state_d;
   logic            req_q, req_d;
   logic            lastGrant_q, lastGrant_d;
   logic [CW-1:0]   snoopCnt_q, snoopCnt_d;
   logic            snp;
   logic            ramAccess;
   logic [1:0]      fillReq;

   assign snp       = ~req_q;
   assign ramAccess = (ramstate == 2'd2);
   assign fillReq   = dREN & cctrans;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         lastGrant_q <= 1'b1;
         snoopCnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         lastGrant_q <= lastGrant_d;
         snoopCnt_q  <= snoopCnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      lastGrant_d = lastGrant_q;
      snoopCnt_d  = snoopCnt_q;
      dwait       = 2'b11;
      dload       = '0;
      ccwait      = 2'b00;
      ccinv       = 2'b00;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;

      case (state_q)
         IDLE: begin
            // Writebacks always win. A tie inside a class goes to the cache not granted last.
            if (|dWEN) begin
               req_d       = (&dWEN) ? ~lastGrant_q : dWEN[1];
               lastGrant_d = req_d;
               state_d     = WB;
            end else if (|fillReq) begin
               req_d       = (&fillReq) ? ~lastGrant_q : fillReq[1];
               lastGrant_d = req_d;
               snoopCnt_d  = '0;
               state_d     = SNOOP;
            end
         end

         WB: begin
            if (!dWEN[req_q]) begin
               state_d = IDLE;
            end else begin
               ramWEN   = 1'b1;
               ramaddr  = daddr[req_q];
               ramstore = dstore[req_q];
               if (ramAccess) begin
                  dwait[req_q] = 1'b0;
                  state_d      = IDLE;
               end
            end
         end

         SNOOP, SWB1, SWB2, LD1, LD2: begin
            // If the requester abandons its fill, the snoop is released without touching RAM.
            if (!dREN[req_q]) begin
               snoopCnt_d = '0;
               state_d    = IDLE;
            end else begin
               ccwait[snp]      = 1'b1;
               ccinv[snp]       = ccwrite[req_q];
               ccsnoopaddr[snp] = daddr[req_q];
               case (state_q)
                  SNOOP: begin
                     if (snoopCnt_q == SNOOP_LAST) begin
                        snoopCnt_d = '0;
                        state_d    = ccwrite[snp] ? SWB1 : LD1;
                     end else begin
                        snoopCnt_d = snoopCnt_q + 1'b1;
                     end
                  end
                  SWB1, SWB2: begin
                     if (dWEN[snp] && (daddr[snp][2] == (state_q == SWB2))) begin
                        ramWEN   = 1'b1;
                        ramaddr  = daddr[snp];
                        ramstore = dstore[snp];
                        if (ramAccess) begin
                           dwait[snp] = 1'b0;
                           state_d    = (state_q == SWB1) ? SWB2 : LD1;
                        end
                     end
                  end
                  default: begin
                     ramREN  = 1'b1;
                     ramaddr = {daddr[req_q][31:3], (state_q == LD2), 2'b00};
                     if (ramAccess) begin
                        dload[req_q] = ramload;
                        dwait[req_q] = 1'b0;
                        state_d      = (state_q == LD1) ? LD2 : IDLE;
                     end
                  end
               endcase
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_coherence_control.sv
// Directed bench for coherence_control.
// It runs fills, dirty snoop writebacks, tie-breaks, WB priority, RAM error, async reset and fill abort.
module tb_coherence_control;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   logic              CLK = 1'b0;
   logic              nRST;
   logic [1:0]        dREN, dWEN, cctrans, ccwrite;
   logic [1:0][31:0]  daddr, dstore;
   logic [1:0]        dwait, ccwait, ccinv;
   logic [1:0][31:0]  dload, ccsnoopaddr;
   logic              ramREN, ramWEN;
   logic [31:0]       ramaddr, ramstore, ramload;
   logic [1:0]        ramstate;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   coherence_control #(.SNOOP_WAIT(2)) dut (
      .CLK(CLK), .nRST(nRST),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .cctrans(cctrans), .ccwrite(ccwrite),
      .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      nRST = 1'b0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
      daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
      #1;
      checkOutput("rst dwait", 32'(dwait), 32'h3);
      checkOutput("rst ccwait", 32'(ccwait), 32'h0);
      checkOutput("rst ramREN", 32'(ramREN), 32'h0);
      checkOutput("rst ramWEN", 32'(ramWEN), 32'h0);
      checkOutput("rst dload0", dload[0], 32'h0);
      @(negedge CLK);
      @(negedge CLK); nRST = 1'b1;

      // Clean fill by cache0.
      @(negedge CLK); dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h80; #1;
      checkOutput("t1 idle dwait", 32'(dwait), 32'h3);
      @(negedge CLK); #1;
      checkOutput("t1 snoop ccwait", 32'(ccwait), 32'h2);
      checkOutput("t1 snoop addr", ccsnoopaddr[1], 32'h80);
      checkOutput("t1 snoop ccinv", 32'(ccinv), 32'h0);
      checkOutput("t1 snoop ramREN", 32'(ramREN), 32'h0);
      @(negedge CLK); #1;
      checkOutput("t1 snoop2 ccwait", 32'(ccwait), 32'h2);
      @(negedge CLK); ramstate = BUSY; #1;
      checkOutput("t1 ld1 ramREN", 32'(ramREN), 32'h1);
      checkOutput("t1 ld1 ramaddr", ramaddr, 32'h80);
      checkOutput("t1 ld1 busy dwait", 32'(dwait), 32'h3);
      @(negedge CLK); ramstate = ACCESS; ramload = 32'h1111; #1;
      checkOutput("t1 ld1 dwait", 32'(dwait), 32'h2);
      checkOutput("t1 ld1 dload", dload[0], 32'h1111);
      @(negedge CLK); ramload = 32'h2222; #1;
      checkOutput("t1 ld2 ramaddr", ramaddr, 32'h84);
      checkOutput("t1 ld2 dwait", 32'(dwait), 32'h2);
      checkOutput("t1 ld2 dload", dload[0], 32'h2222);
      @(negedge CLK); dREN = '0; cctrans = '0; ramstate = FREE; #1;
      checkOutput("t1 done ccwait", 32'(ccwait), 32'h0);
      checkOutput("t1 done ramREN", 32'(ramREN), 32'h0);

      // Cache1 fill for write; cache0 holds the line dirty.
      @(negedge CLK); dREN = 2'b10; cctrans = 2'b10; ccwrite = 2'b11; daddr[1] = 32'h100; #1;
      checkOutput("t2 idle dwait", 32'(dwait), 32'h3);
      @(negedge CLK); #1;
      checkOutput("t2 snoop ccwait", 32'(ccwait), 32'h1);
      checkOutput("t2 snoop ccinv", 32'(ccinv), 32'h1);
      checkOutput("t2 snoop addr", ccsnoopaddr[0], 32'h100);
      @(negedge CLK); #1;
      checkOutput("t2 snoop2 ccinv", 32'(ccinv), 32'h1);
      @(negedge CLK); dWEN = 2'b01; daddr[0] = 32'h100; dstore[0] = 32'hAAAA; ramstate = ACCESS; #1;
      checkOutput("t2 swb1 ramWEN", 32'(ramWEN), 32'h1);
      checkOutput("t2 swb1 ramaddr", ramaddr, 32'h100);
      checkOutput("t2 swb1 ramstore", ramstore, 32'hAAAA);
      checkOutput("t2 swb1 dwait", 32'(dwait), 32'h2);
      @(negedge CLK); daddr[0] = 32'h104; dstore[0] = 32'hBBBB; #1;
      checkOutput("t2 swb2 ramaddr", ramaddr, 32'h104);
      checkOutput("t2 swb2 ramstore", ramstore, 32'hBBBB);
      checkOutput("t2 swb2 dwait", 32'(dwait), 32'h2);
      @(negedge CLK); dWEN = '0; ramload = 32'hAAAA; #1;
      checkOutput("t2 ld1 ramREN", 32'(ramREN), 32'h1);
      checkOutput("t2 ld1 ramWEN", 32'(ramWEN), 32'h0);
      checkOutput("t2 ld1 ramaddr", ramaddr, 32'h100);
      checkOutput("t2 ld1 dload", dload[1], 32'hAAAA);
      checkOutput("t2 ld1 dwait", 32'(dwait), 32'h1);
      @(negedge CLK); ramload = 32'hBBBB; #1;
      checkOutput("t2 ld2 ramaddr", ramaddr, 32'h104);
      checkOutput("t2 ld2 dload", dload[1], 32'hBBBB);
      checkOutput("t2 ld2 dwait", 32'(dwait), 32'h1);
      @(negedge CLK); dREN = '0; cctrans = '0; ccwrite = '0; ramstate = FREE; #1;
      checkOutput("t2 done ccwait", 32'(ccwait), 32'h0);
      checkOutput("t2 done ccinv", 32'(ccinv), 32'h0);

      // Simultaneous fills after reset: cache0 first, then cache1 wins the repeated tie.
      @(negedge CLK); nRST = 1'b0;
      @(negedge CLK); nRST = 1'b1; dREN = 2'b11; cctrans = 2'b11;
      daddr[0] = 32'h200; daddr[1] = 32'h300; ramstate = ACCESS; ramload = 32'h5; #1;
      checkOutput("t3 idle dwait", 32'(dwait), 32'h3);
      @(negedge CLK); #1;
      checkOutput("t3 c0 ccwait", 32'(ccwait), 32'h2);
      checkOutput("t3 c0 snoop addr", ccsnoopaddr[1], 32'h200);
      checkOutput("t3 c0 snoop dwait", 32'(dwait), 32'h3);
      @(negedge CLK);
      @(negedge CLK); #1;
      checkOutput("t3 c0 ld1 ramaddr", ramaddr, 32'h200);
      checkOutput("t3 c0 ld1 dwait", 32'(dwait), 32'h2);
      @(negedge CLK); #1;
      checkOutput("t3 c0 ld2 ramaddr", ramaddr, 32'h204);
      checkOutput("t3 c0 ld2 dwait", 32'(dwait), 32'h2);
      @(negedge CLK); #1;
      checkOutput("t3 tie idle dwait", 32'(dwait), 32'h3);
      checkOutput("t3 tie idle ccwait", 32'(ccwait), 32'h0);
      @(negedge CLK); #1;
      checkOutput("t3 c1 ccwait", 32'(ccwait), 32'h1);
      checkOutput("t3 c1 snoop addr", ccsnoopaddr[0], 32'h300);
      @(negedge CLK);
      @(negedge CLK); #1;
      checkOutput("t3 c1 ld1 ramaddr", ramaddr, 32'h300);
      checkOutput("t3 c1 ld1 dwait", 32'(dwait), 32'h1);
      checkOutput("t3 c1 ld1 dload", dload[1], 32'h5);
      @(negedge CLK); #1;
      checkOutput("t3 c1 ld2 ramaddr", ramaddr, 32'h304);
      checkOutput("t3 c1 ld2 dwait", 32'(dwait), 32'h1);
      @(negedge CLK); dREN = '0; cctrans = '0; ramstate = FREE;

      // Writeback from cache1 beats a fill from cache0.
      @(negedge CLK); dWEN = 2'b10; daddr[1] = 32'h400; dstore[1] = 32'hCAFE;
      dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h80; #1;
      checkOutput("t4 idle dwait", 32'(dwait), 32'h3);
      checkOutput("t4 idle ramWEN", 32'(ramWEN), 32'h0);
      @(negedge CLK); ramstate = ACCESS; #1;
      checkOutput("t4 wb ramWEN", 32'(ramWEN), 32'h1);
      checkOutput("t4 wb ramaddr", ramaddr, 32'h400);
      checkOutput("t4 wb ramstore", ramstore, 32'hCAFE);
      checkOutput("t4 wb dwait", 32'(dwait), 32'h1);
      checkOutput("t4 wb ccwait", 32'(ccwait), 32'h0);
      @(negedge CLK); dWEN = '0; ramstate = FREE; #1;
      checkOutput("t4 idle2 dwait", 32'(dwait), 32'h3);
      checkOutput("t4 idle2 ramWEN", 32'(ramWEN), 32'h0);
      @(negedge CLK); #1;
      checkOutput("t4 snoop ccwait", 32'(ccwait), 32'h2);
      checkOutput("t4 snoop addr", ccsnoopaddr[1], 32'h80);
      @(negedge CLK);
      @(negedge CLK); ramstate = ERROR; #1;
      checkOutput("t4 err ramREN", 32'(ramREN), 32'h1);
      checkOutput("t4 err dwait", 32'(dwait), 32'h3);
      @(negedge CLK); ramstate = ACCESS; ramload = 32'h77; #1;
      checkOutput("t4 ld1 dwait", 32'(dwait), 32'h2);
      checkOutput("t4 ld1 dload", dload[0], 32'h77);

      // Asynchronous reset during LD2 while RAM is busy.
      @(negedge CLK); ramstate = BUSY; #1;
      checkOutput("t5 ld2 ramREN", 32'(ramREN), 32'h1);
      checkOutput("t5 ld2 ramaddr", ramaddr, 32'h84);
      checkOutput("t5 ld2 dwait", 32'(dwait), 32'h3);
      #1 nRST = 1'b0; #1;
      checkOutput("t5 arst ramREN", 32'(ramREN), 32'h0);
      checkOutput("t5 arst ramaddr", ramaddr, 32'h0);
      checkOutput("t5 arst dwait", 32'(dwait), 32'h3);
      checkOutput("t5 arst ccwait", 32'(ccwait), 32'h0);
      checkOutput("t5 arst snoop addr", ccsnoopaddr[1], 32'h0);
      @(negedge CLK); nRST = 1'b1; ramstate = FREE; #1;
      checkOutput("t5 idle dwait", 32'(dwait), 32'h3);
      checkOutput("t5 idle ccwait", 32'(ccwait), 32'h0);
      @(negedge CLK); #1;
      checkOutput("t5 snoop ccwait", 32'(ccwait), 32'h2);
      checkOutput("t5 snoop addr", ccsnoopaddr[1], 32'h80);

      // Requester drops its fill mid-snoop.
      @(negedge CLK); dREN = '0; cctrans = '0;
      @(negedge CLK); #1;
      checkOutput("t6 abort ccwait", 32'(ccwait), 32'h0);
      checkOutput("t6 abort ramREN", 32'(ramREN), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
